monpro_radix: RTL and testbench
===============================

MONPRO_RADIX -- requirements
Module: monpro_radix

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 256, operand/modulus width in bits.
REQ-002 SHALL have parameter RADIX_LOG2, default 2, bits of A consumed per iteration; legal 1..4, DATAWIDTH mod RADIX_LOG2 == 0, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  request; accepted only on an edge where start && ready.
REQ-006 SHALL have port ready  output  1  high only in IDLE.
REQ-007 SHALL have ports i_A, i_B, i_N  input  DATAWIDTH each  operands and modulus; sampled only on acceptance.
REQ-008 SHALL have port i_Nprime  input  RADIX_LOG2  -N^-1 mod 2^RADIX_LOG2; sampled on acceptance.
REQ-009 SHALL have port i_lazy  input  1  1 = skip final subtraction; sampled on acceptance.
REQ-010 SHALL have port o_valid  output  1  result available.
REQ-011 SHALL have port i_out_ready  input  1  downstream accepts result when o_valid && i_out_ready.
REQ-012 SHALL have port o_U  output  DATAWIDTH+1  result; bit DATAWIDTH nonzero only in lazy mode.

Function
REQ-013 SHALL compute U = A*B*2^-DATAWIDTH mod N for odd N, A < N, B < N; result independent of RADIX_LOG2.
REQ-014 SHALL use FSM states IDLE, ITER, FINAL, DONE; IDLE->ITER on acceptance, ITER->FINAL after D = DATAWIDTH/RADIX_LOG2 iterations, FINAL->DONE after one cycle, DONE->IDLE on output handshake.
REQ-015 SHALL on acceptance clear accumulator U, capture A, B, N, N', lazy, and clear digit counter.
REQ-016 SHALL per ITER cycle i: a_i = A[i*k +: k], T = U + a_i*B, q = (T[k-1:0]*N') mod 2^k, U <= (T + q*N) >> k, where k = RADIX_LOG2.
REQ-017 SHALL size T at DATAWIDTH+k+2 bits without overflow; invariant U < 2N holds after every iteration.
REQ-018 SHALL in FINAL register o_U = U-N if U >= N and lazy == 0, else U.
REQ-019 SHALL assert o_valid on the cycle after the FINAL edge: accept edge at t0, o_valid visible after edge t0+D+1.
REQ-020 SHALL hold o_valid and o_U stable in DONE while i_out_ready is low, for any number of cycles.
REQ-021 SHALL on the handshake edge deassert o_valid and return to IDLE; ready is high the following cycle, never the same cycle.
REQ-022 SHALL ignore start whenever ready is low, including during DONE and on the handshake edge.
REQ-023 SHALL ignore changes to i_A, i_B, i_N, i_Nprime, i_lazy after acceptance.
REQ-024 SHALL give A = 0 or B = 0 result 0 in both modes.

Reset
REQ-025 SHALL on rst high at any edge, including mid-ITER or DONE, go to IDLE with ready = 1, o_valid = 0, o_U = 0, counter = 0; in-flight result discarded.
REQ-026 SHALL give rst priority over start and i_out_ready on the same edge.

Structure
REQ-027 SHALL place the FSM state enum and a function returning D = DATAWIDTH/RADIX_LOG2 in shared package monpro_pkg.
REQ-028 SHALL factor one iteration of REQ-016 into combinational sub-module monpro_digit_step, parametrised by DATAWIDTH and RADIX_LOG2.
REQ-029 SHALL contain no multipliers wider than RADIX_LOG2 x DATAWIDTH.

Verification
REQ-030 SHALL cover DATAWIDTH=256, A=0x12d456b52fa348795ea45d718801f8b06f36e8dfb75a67edb55c3f24802639dc, B=0xa428af0aabd7dd0c3010b45dbc7634cb64d24c0582925701dd93aa34c2f108d, N=0x19bfb084128dd8d58b7ab2b15fc9b082746e37ffd238398df42fa049b078ccbd, lazy=0, for RADIX_LOG2=1/2/4 with N'=1/3/0xb -> o_U=0x8135951beae3febd4223575ca05ef93dfa1f34400e1a532d94ee29520104d16, o_valid after exactly D+2 cycles (258/130/66).
REQ-031 SHALL cover DATAWIDTH=8, N=13, A=5, B=7, lazy=0 -> o_U=1; same with lazy=1 -> o_U ≡ 1 mod 13 and o_U < 26.
REQ-032 SHALL cover A=0, B=7, N=13 -> o_U=0 in both modes.
REQ-033 SHALL cover i_out_ready low 5 cycles after o_valid, start pulsed and operands changed meanwhile -> o_U and o_valid unchanged, ready stays 0, no second job; ready=1 one cycle after handshake.
REQ-034 SHALL cover rst pulsed at iteration 10 of a 256-bit job -> next cycle ready=1, o_valid=0, o_U=0; new job then returns correct result.

Source files
------------

// File: rtl/monpro_pkg.sv
// Shared definitions for the radix-2^k Montgomery multiplier.
package monpro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINAL,
    DONE
  } state_t;

  // Number of digit iterations needed to consume the whole A operand.
  function automatic int num_digits(input int datawidth, input int radix_log2);
    return datawidth / radix_log2;
  endfunction

endpackage

// File: rtl/monpro_digit_step.sv
// One radix-2^k Montgomery iteration: U' = (U + a*B + q*N) >> k.
module monpro_digit_step #(
  parameter int DATAWIDTH  = 256,
  parameter int RADIX_LOG2 = 2
) (
  input  logic [DATAWIDTH:0]    u,
  input  logic [RADIX_LOG2-1:0] a_digit,
  input  logic [DATAWIDTH-1:0]  b,
  input  logic [DATAWIDTH-1:0]  n,
  input  logic [RADIX_LOG2-1:0] nprime,
  output logic [DATAWIDTH:0]    u_next
);

  localparam int K  = RADIX_LOG2;
  localparam int PW = DATAWIDTH + K;
  localparam int TW = DATAWIDTH + K + 2;
  localparam int UW = DATAWIDTH + 1;

  logic [PW-1:0] ab;
  logic [PW-1:0] qn;
  logic [TW-1:0] t;
  logic [TW-1:0] s;
  logic [K-1:0]  q;

  // Products are only k x DATAWIDTH wide; the zero padding just sizes the result.
  // With U < 2N the sum stays below 2^(k+1)*N, so TW bits never overflow.
  always_comb begin
    ab     = {{DATAWIDTH{1'b0}}, a_digit} * {{K{1'b0}}, b};
    t      = {{(K + 1){1'b0}}, u} + {2'b00, ab};
    q      = t[K-1:0] * nprime;
    qn     = {{DATAWIDTH{1'b0}}, q} * {{K{1'b0}}, n};
    s      = t + {2'b00, qn};
    u_next = UW'(s >> K);
  end

endmodule

// File: rtl/monpro_radix.sv
// Iterative Montgomery multiplier U = A*B*2^-DATAWIDTH mod N, k bits of A per cycle.
module monpro_radix
  import monpro_pkg::*;
#(
  parameter int DATAWIDTH  = 256,
  parameter int RADIX_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [DATAWIDTH-1:0]  i_A,
  input  logic [DATAWIDTH-1:0]  i_B,
  input  logic [DATAWIDTH-1:0]  i_N,
  input  logic [RADIX_LOG2-1:0] i_Nprime,
  input  logic                  i_lazy,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  output logic [DATAWIDTH:0]    o_U
);

  localparam int D  = num_digits(DATAWIDTH, RADIX_LOG2);
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  if (RADIX_LOG2 < 1 || RADIX_LOG2 > 4) begin : g_bad_radix
    $error("monpro_radix: RADIX_LOG2 must be in 1..4");
  end
  if ((DATAWIDTH % RADIX_LOG2) != 0) begin : g_bad_width
    $error("monpro_radix: DATAWIDTH must be a multiple of RADIX_LOG2");
  end

  state_t                state;
  state_t                state_next;
  logic [DATAWIDTH-1:0]  a_reg;
  logic [DATAWIDTH-1:0]  b_reg;
  logic [DATAWIDTH-1:0]  n_reg;
  logic [RADIX_LOG2-1:0] np_reg;
  logic                  lazy_reg;
  logic [DATAWIDTH:0]    u_reg;
  logic [DATAWIDTH:0]    u_next;
  logic [CW-1:0]         cnt;

  monpro_digit_step #(
    .DATAWIDTH (DATAWIDTH),
    .RADIX_LOG2(RADIX_LOG2)
  ) u_step (
    .u      (u_reg),
    .a_digit(a_reg[RADIX_LOG2-1:0]),
    .b      (b_reg),
    .n      (n_reg),
    .nprime (np_reg),
    .u_next (u_next)
  );

  // State register; reset wins over any request or handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus the ready/valid flags, which depend only on the state.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = ITER;
      end
      ITER: begin
        if (cnt == LAST) state_next = FINAL;
      end
      FINAL: state_next = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, shift A one digit per iteration, reduce in FINAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      n_reg    <= '0;
      np_reg   <= '0;
      lazy_reg <= 1'b0;
      u_reg    <= '0;
      cnt      <= '0;
      o_U      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= i_A;
            b_reg    <= i_B;
            n_reg    <= i_N;
            np_reg   <= i_Nprime;
            lazy_reg <= i_lazy;
            u_reg    <= '0;
            cnt      <= '0;
          end
        end
        ITER: begin
          u_reg <= u_next;
          a_reg <= a_reg >> RADIX_LOG2;
          cnt   <= cnt + 1'b1;
        end
        FINAL: begin
          if (!lazy_reg && (u_reg >= {1'b0, n_reg})) o_U <= u_reg - {1'b0, n_reg};
          else                                       o_U <= u_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_monpro_radix.sv
// Directed self-checking bench for monpro_radix at 256 bits (k=1,2,4) and 8 bits (k=2).
module tb_monpro_radix;

  localparam logic [255:0] A_BIG = 256'h12d456b52fa348795ea45d718801f8b06f36e8dfb75a67edb55c3f24802639dc;
  localparam logic [255:0] B_BIG = 256'h0a428af0aabd7dd0c3010b45dbc7634cb64d24c0582925701dd93aa34c2f108d;
  localparam logic [255:0] N_BIG = 256'h19bfb084128dd8d58b7ab2b15fc9b082746e37ffd238398df42fa049b078ccbd;
  localparam logic [256:0] U_BIG = 257'h08135951beae3febd4223575ca05ef93dfa1f34400e1a532d94ee29520104d16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [255:0] a_w = '0;
  logic [255:0] b_w = '0;
  logic [255:0] n_w = '0;
  logic         lazy = 1'b0;
  logic         ready1, ready2, ready4;
  logic         valid1, valid2, valid4;
  logic [256:0] u1, u2, u4;

  logic         start8 = 1'b0;
  logic         out_ready8 = 1'b0;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic [7:0]   n8 = '0;
  logic [1:0]   np8 = '0;
  logic         lazy8 = 1'b0;
  logic         ready8, valid8;
  logic [8:0]   u8;

  int total = 0;
  int bad = 0;
  int lat1, lat2, lat4, lat8;

  monpro_radix #(.DATAWIDTH(256), .RADIX_LOG2(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .ready(ready1),
    .i_A(a_w), .i_B(b_w), .i_N(n_w), .i_Nprime(1'b1), .i_lazy(lazy),
    .o_valid(valid1), .i_out_ready(out_ready), .o_U(u1)
  );

  monpro_radix #(.DATAWIDTH(256), .RADIX_LOG2(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .ready(ready2),
    .i_A(a_w), .i_B(b_w), .i_N(n_w), .i_Nprime(2'd3), .i_lazy(lazy),
    .o_valid(valid2), .i_out_ready(out_ready), .o_U(u2)
  );

  monpro_radix #(.DATAWIDTH(256), .RADIX_LOG2(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .ready(ready4),
    .i_A(a_w), .i_B(b_w), .i_N(n_w), .i_Nprime(4'hb), .i_lazy(lazy),
    .o_valid(valid4), .i_out_ready(out_ready), .o_U(u4)
  );

  monpro_radix #(.DATAWIDTH(8), .RADIX_LOG2(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .ready(ready8),
    .i_A(a8), .i_B(b8), .i_N(n8), .i_Nprime(np8), .i_lazy(lazy8),
    .o_valid(valid8), .i_out_ready(out_ready8), .o_U(u8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one 8-bit job and wait (bounded) for o_valid; lat counts the accept edge as cycle 1.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                               input logic [1:0] np, input logic lz, output int lat);
    a8 = a; b8 = b; n8 = n; np8 = np; lazy8 = lz;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    for (int c = 2; c <= 40 && lat == 0; c++) begin
      tick();
      if (valid8) lat = c;
    end
  endtask

  task automatic handshake8(input string tag);
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    checkOutput({tag, "_ready_after_hs"}, ready8, 1'b1);
    checkOutput({tag, "_valid_after_hs"}, valid8, 1'b0);
  endtask

  // Launch the 256-bit vector on all three radices and record each first-valid cycle.
  task automatic runBig();
    a_w = A_BIG; b_w = B_BIG; n_w = N_BIG; lazy = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_w = '1; b_w = '0;
    lat1 = 0; lat2 = 0; lat4 = 0;
    for (int c = 2; c <= 300 && (lat1 == 0 || lat2 == 0 || lat4 == 0); c++) begin
      tick();
      if (valid1 && lat1 == 0) lat1 = c;
      if (valid2 && lat2 == 0) lat2 = c;
      if (valid4 && lat4 == 0) lat4 = c;
    end
  endtask

  initial begin
    $display("[TB] starting monpro_radix checks");

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_ready1", ready1, 1'b1);
    checkOutput("rst_valid1", valid1, 1'b0);
    checkOutput("rst_u1", u1, '0);
    checkOutput("rst_ready4", ready4, 1'b1);
    checkOutput("rst_ready8", ready8, 1'b1);
    checkOutput("rst_valid8", valid8, 1'b0);
    checkOutput("rst_u8", u8, '0);

    // 256-bit reference vector, all three radices
    runBig();
    checkOutput("big_lat_k1", lat1, 258);
    checkOutput("big_lat_k2", lat2, 130);
    checkOutput("big_lat_k4", lat4, 66);
    checkOutput("big_u_k1", u1, U_BIG);
    checkOutput("big_u_k2", u2, U_BIG);
    checkOutput("big_u_k4", u4, U_BIG);
    checkOutput("big_valid_k4_held", valid4, 1'b1);
    checkOutput("big_ready_k4_done", ready4, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("big_hs_ready1", ready1, 1'b1);
    checkOutput("big_hs_ready2", ready2, 1'b1);
    checkOutput("big_hs_ready4", ready4, 1'b1);
    checkOutput("big_hs_valid4", valid4, 1'b0);

    // 8-bit: 5*7*2^-8 mod 13 = 1 in both modes
    applyStimulus(8'd5, 8'd7, 8'd13, 2'd3, 1'b0, lat8);
    checkOutput("s_lat", lat8, 6);
    checkOutput("s_5x7", u8, 9'd1);
    handshake8("s_5x7");
    applyStimulus(8'd5, 8'd7, 8'd13, 2'd3, 1'b1, lat8);
    checkOutput("s_5x7_lazy", u8, 9'd1);
    handshake8("s_5x7_lazy");

    // Zero operands
    applyStimulus(8'd0, 8'd7, 8'd13, 2'd3, 1'b0, lat8);
    checkOutput("s_a0", u8, 9'd0);
    handshake8("s_a0");
    applyStimulus(8'd0, 8'd7, 8'd13, 2'd3, 1'b1, lat8);
    checkOutput("s_a0_lazy", u8, 9'd0);
    handshake8("s_a0_lazy");
    applyStimulus(8'd7, 8'd0, 8'd13, 2'd3, 1'b1, lat8);
    checkOutput("s_b0_lazy", u8, 9'd0);
    handshake8("s_b0_lazy");

    // N=251: loop ends at 452, so final subtraction gives 201; lazy keeps 452 with bit 8 set
    applyStimulus(8'd250, 8'd250, 8'd251, 2'd1, 1'b0, lat8);
    checkOutput("s_250sq", u8, 9'd201);
    handshake8("s_250sq");
    applyStimulus(8'd250, 8'd250, 8'd251, 2'd1, 1'b1, lat8);
    checkOutput("s_250sq_lazy", u8, 9'h1c4);
    handshake8("s_250sq_lazy");

    // Back-pressure: result held 5 cycles while start toggles and operands change
    applyStimulus(8'd250, 8'd250, 8'd251, 2'd1, 1'b0, lat8);
    for (int i = 0; i < 5; i++) begin
      start8 = (i % 2 == 0);
      a8 = 8'(i * 37 + 3); b8 = 8'(i + 1); n8 = 8'd13; lazy8 = 1'b1;
      tick();
      checkOutput("hold_u", u8, 9'd201);
      checkOutput("hold_valid", valid8, 1'b1);
      checkOutput("hold_ready", ready8, 1'b0);
    end
    start8 = 1'b1;
    out_ready8 = 1'b1;
    tick();
    start8 = 1'b0;
    out_ready8 = 1'b0;
    checkOutput("hold_hs_ready", ready8, 1'b1);
    checkOutput("hold_hs_valid", valid8, 1'b0);
    tick();
    checkOutput("hold_no_second_job", ready8, 1'b1);

    // Reset mid-iteration with start asserted on the same edge
    a_w = A_BIG; b_w = B_BIG; n_w = N_BIG;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("mid_busy_ready2", ready2, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checkOutput("mid_rst_ready1", ready1, 1'b1);
    checkOutput("mid_rst_ready2", ready2, 1'b1);
    checkOutput("mid_rst_ready4", ready4, 1'b1);
    checkOutput("mid_rst_valid2", valid2, 1'b0);
    checkOutput("mid_rst_u1", u1, '0);
    checkOutput("mid_rst_u4", u4, '0);

    // Fresh job after the aborted one
    runBig();
    checkOutput("re_lat_k2", lat2, 130);
    checkOutput("re_u_k1", u1, U_BIG);
    checkOutput("re_u_k2", u2, U_BIG);
    checkOutput("re_u_k4", u4, U_BIG);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
